// File: rtl/arm_rf_pkg.sv
// Shared types for the ARM register-file write-back path: request record,
// source tag and register-decode helper.
package arm_rf_pkg;

  localparam int RF_NREGS = 16;
  localparam int RF_AW    = 4;
  localparam int RF_DW    = 32;

  typedef struct packed {
    logic [RF_AW-1:0] rd;
    logic [RF_DW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  function automatic logic [RF_NREGS-1:0] rd_onehot(input logic [RF_AW-1:0] rd);
    rd_onehot = {{(RF_NREGS-1){1'b0}}, 1'b1} << rd;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; DEPTH must be a power of two so the
// extra pointer bit distinguishes full from empty.
module wb_fifo
  import arm_rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic    clk,
  input  logic    clr,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t din,
  output wb_req_t dout,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  wb_req_t     mem_r [DEPTH];
  logic        do_push_s;
  logic        do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update; reset flushes the contents.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter sharing the RegFile write port between the ALU and the
// load-return FIFO. Optional bypass ports are enabled by RF_WB_FWD_EN.
module rf_wb_arbiter
  import arm_rf_pkg::*;
#(
  parameter int STARVE_MAX = 3,
  parameter int MEM_DEPTH  = 2
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                alu_valid,
  input  logic [RF_AW-1:0]    alu_rd,
  input  logic [RF_DW-1:0]    alu_data,
  output logic                alu_ready,
  input  logic                mem_valid,
  input  logic [RF_AW-1:0]    mem_rd,
  input  logic [RF_DW-1:0]    mem_data,
  output logic                mem_ovf,
  output logic                rf_le,
  output logic [RF_AW-1:0]    rf_rc,
  output logic [RF_DW-1:0]    rf_i,
`ifdef RF_WB_FWD_EN
  input  logic [RF_AW-1:0]    ra,
  input  logic [RF_AW-1:0]    rb,
  output logic                fwd_a,
  output logic                fwd_b,
  output logic [RF_DW-1:0]    fwd_data,
`endif
  output logic [RF_NREGS-1:0] pend
);

  localparam int WW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [WW-1:0] WAIT_MAX = WW'(STARVE_MAX);
  localparam int CW = $clog2(MEM_DEPTH + 1);

  logic                fifo_full_s;
  logic                fifo_empty_s;
  wb_req_t             head_s;
  wb_req_t             push_req_s;
  wb_req_t             sel_s;
  wb_src_e             src_s;
  logic                alu_win_s;
  logic                alu_grant_s;
  logic                mem_grant_s;
  logic                push_ok_s;
  logic [WW-1:0]       wait_r;
  logic [CW-1:0]       cnt_r     [RF_NREGS];
  logic [CW-1:0]       cnt_nxt_s [RF_NREGS];
  logic [RF_NREGS-1:0] queued_s;

  assign push_req_s = '{rd: mem_rd, data: mem_data};

  wb_fifo #(.DEPTH(MEM_DEPTH)) u_fifo (
    .clk   (clk),
    .clr   (clr),
    .push  (push_ok_s),
    .pop   (mem_grant_s),
    .din   (push_req_s),
    .dout  (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Grant decision and write-port source selection.
  always_comb begin
    alu_win_s   = fifo_empty_s || (wait_r == WAIT_MAX);
    alu_grant_s = clr && alu_valid && alu_win_s;
    mem_grant_s = clr && !fifo_empty_s && !alu_grant_s;
    push_ok_s   = clr && mem_valid && (!fifo_full_s || mem_grant_s);
    if (alu_grant_s) begin
      src_s = WB_ALU;
    end else begin
      src_s = WB_MEM;
    end
    case (src_s)
      WB_ALU:  sel_s = '{rd: alu_rd, data: alu_data};
      WB_MEM:  sel_s = head_s;
      default: sel_s = head_s;
    endcase
  end

  assign alu_ready = alu_grant_s;

  // Starvation counter: counts consecutive lost cycles of a waiting ALU.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wait_r <= '0;
    end else if (alu_valid && !alu_grant_s) begin
      if (wait_r != WAIT_MAX) wait_r <= wait_r + WW'(1);
    end else begin
      wait_r <= '0;
    end
  end

  // Registered write port; reset discards any presented write.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rf_le <= 1'b1;
      rf_rc <= '0;
      rf_i  <= '0;
    end else if (alu_grant_s || mem_grant_s) begin
      rf_le <= 1'b0;
      rf_rc <= sel_s.rd;
      rf_i  <= sel_s.data;
    end else begin
      rf_le <= 1'b1;
    end
  end

  // Sticky overflow: full FIFO with no same-cycle pop drops the push.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      mem_ovf <= 1'b0;
    end else if (mem_valid && fifo_full_s && !mem_grant_s) begin
      mem_ovf <= 1'b1;
    end else begin
      mem_ovf <= mem_ovf;
    end
  end

  // Per-register count of queued loads, so duplicate targets are tracked.
  always_comb begin
    for (int r = 0; r < RF_NREGS; r++) begin
      cnt_nxt_s[r] = cnt_r[r]
                   + {{(CW-1){1'b0}}, (push_ok_s && (mem_rd == RF_AW'(r)))}
                   - {{(CW-1){1'b0}}, (mem_grant_s && (head_s.rd == RF_AW'(r)))};
      queued_s[r]  = (cnt_r[r] != '0);
    end
  end

  // Scoreboard count registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int r = 0; r < RF_NREGS; r++) cnt_r[r] <= '0;
    end else begin
      for (int r = 0; r < RF_NREGS; r++) cnt_r[r] <= cnt_nxt_s[r];
    end
  end

  assign pend = queued_s | (rf_le ? {RF_NREGS{1'b0}} : rd_onehot(rf_rc));

`ifdef RF_WB_FWD_EN
  assign fwd_a    = !rf_le && (rf_rc == ra);
  assign fwd_b    = !rf_le && (rf_rc == rb);
  assign fwd_data = rf_i;
`endif

endmodule
